// File: rtl/xm23_mem_pkg.sv
// xm23_mem_pkg: shared types and constants for the data-memory arbiter.
package xm23_mem_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, ACK, WAIT_DROP} state_t;
  typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;
  typedef struct packed {
    req_id_t id;
    logic    we;
    logic    bsel;
    logic    lsb;
    logic    err;
  } txn_t;
endpackage

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer: byte-lane steering between a 16-bit port and the 16-bit RAM word.
module dmem_lane_steer
  import xm23_mem_pkg::*;
(
  input  logic        bsel,
  input  logic        lsb,
  input  logic [15:0] wdata,
  input  logic [15:0] q,
  output logic [15:0] wr_data,
  output logic [1:0]  byteena,
  output logic [15:0] rd_data
);
  always_comb begin
    wr_data = bsel ? {2{wdata[7:0]}} : wdata;
    byteena = !bsel ? LANE_BOTH : lsb ? LANE_HI : LANE_LO;
    rd_data = !bsel ? q : {8'h00, lsb ? q[15:8] : q[7:0]};
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates CPU and debug ports onto the single-port data RAM,
// with a starvation guard that lets a waiting debug request in after STARVE_LIMIT CPU grants.
module dmem_arbiter
  import xm23_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [15:0]       dbg_addr,
  input  logic [15:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [15:0]       dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic [1:0]        ram_byteena,
  input  logic [15:0]       ram_q,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  state_t        state, next_state;
  txn_t          txn, cand;
  logic [SW-1:0] streak;
  logic [15:0]   c_addr, c_wdata, st_wdata, st_rdata;
  logic [1:0]    st_be;
  logic          cpu_win, grant, win_req;
  always_comb begin
    cpu_win   = cpu_req && !(dbg_req && streak == LIMIT);
    grant     = state == IDLE && (cpu_req || dbg_req);
    win_req   = txn.id == REQ_CPU ? cpu_req : dbg_req;
    c_addr    = cpu_win ? cpu_addr : dbg_addr & 16'hFFFE;
    c_wdata   = cpu_win ? cpu_wdata : dbg_wdata;
    cand.id   = cpu_win ? REQ_CPU : REQ_DBG;
    cand.we   = cpu_win ? cpu_we : dbg_we;
    cand.bsel = cpu_win && cpu_byte;
    cand.lsb  = c_addr[0];
    cand.err  = cpu_win && !cpu_byte && cpu_addr[0];
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cpu_req || dbg_req) next_state = cand.err ? ACK : ISSUE;
      ISSUE:     next_state = txn.we ? ACK : CAPTURE;
      CAPTURE:   next_state = ACK;
      ACK:       next_state = WAIT_DROP;
      WAIT_DROP: if (!win_req) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // Steering sees the candidate while idle and the latched transaction afterwards.
  dmem_lane_steer u_steer (
    .bsel    (state == IDLE ? cand.bsel : txn.bsel),
    .lsb     (state == IDLE ? cand.lsb : txn.lsb),
    .wdata   (c_wdata),
    .q       (ram_q),
    .wr_data (st_wdata),
    .byteena (st_be),
    .rd_data (st_rdata)
  );
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      txn         <= '0;
      streak      <= '0;
      busy        <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      ram_wren    <= 1'b0;
      ram_byteena <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
    end else begin
      busy     <= next_state != IDLE;
      cpu_ack  <= next_state == WAIT_DROP && txn.id == REQ_CPU;
      dbg_ack  <= next_state == WAIT_DROP && txn.id == REQ_DBG;
      cpu_err  <= next_state == WAIT_DROP && txn.id == REQ_CPU && txn.err;
      ram_wren <= grant && cand.we && !cand.err;
      // cpu_win is false once streak hits LIMIT with debug waiting, so this saturates
      if (state == IDLE) streak <= dbg_req && cpu_win ? streak + SW'(1) : '0;
      if (grant) begin
        txn         <= cand;
        ram_addr    <= ADDR_W'(c_addr[15:1]);
        ram_data    <= st_wdata;
        ram_byteena <= st_be;
        if (cand.err) cpu_rdata <= '0;
      end
      if (state == CAPTURE && txn.id == REQ_CPU) cpu_rdata <= st_rdata;
      if (state == CAPTURE && txn.id == REQ_DBG) dbg_rdata <= st_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  logic clk_in = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, cpu_byte = 0, dbg_req = 0, dbg_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0, ram_q = 0;
  logic cpu_ack, cpu_err, dbg_ack, ram_wren, busy;
  logic [15:0] cpu_rdata, dbg_rdata, ram_data;
  logic [14:0] ram_addr;
  logic [1:0] ram_byteena;
  int checks = 0, errors = 0;
  always #10 clk_in = ~clk_in;
  dmem_arbiter #(.ADDR_W(15), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_q(ram_q), .busy(busy)
  );
  logic [15:0] mem [0:32767];
  logic [15:0] mmem [0:32767];
  always @(posedge clk_in) begin
    if (ram_wren && ram_byteena[0]) mem[ram_addr][7:0] <= ram_data[7:0];
    if (ram_wren && ram_byteena[1]) mem[ram_addr][15:8] <= ram_data[15:8];
    ram_q <= mem[ram_addr];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Model: one transaction at a time, ack after a fixed latency, held while the winner requests.
  bit m_act = 0, m_ackon = 0, m_win = 0, m_we = 0, m_bsel = 0, m_err = 0, m_dbgwin = 0;
  int m_cnt = 0, m_lat = 0, m_streak = 0;
  logic [15:0] m_addr = 0, m_wdata = 0, m_rdata = 0, m_word = 0;
  always begin
    @(posedge clk_in or posedge reset);
    if (reset) begin
      m_act = 0; m_ackon = 0; m_streak = 0;
    end else if (!m_act) begin
      m_dbgwin = dbg_req && (!cpu_req || m_streak == LIMIT);
      if (cpu_req || dbg_req) begin
        m_act = 1; m_cnt = 0; m_ackon = 0; m_win = m_dbgwin;
        if (m_dbgwin) begin
          m_we = dbg_we; m_bsel = 0; m_err = 0; m_addr = {dbg_addr[15:1], 1'b0}; m_wdata = dbg_wdata;
        end else begin
          m_we = cpu_we; m_bsel = cpu_byte; m_err = !cpu_byte && cpu_addr[0]; m_addr = cpu_addr; m_wdata = cpu_wdata;
        end
        m_lat = m_err ? 1 : m_we ? 2 : 3;
        m_word = mmem[m_addr[15:1]];
        m_rdata = m_err ? 16'h0 : !m_bsel ? m_word : {8'h00, m_addr[0] ? m_word[15:8] : m_word[7:0]};
        if (m_dbgwin || !dbg_req) m_streak = 0;
        else m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
      end else m_streak = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 1 && m_we && !m_err) begin
        if (!m_bsel) mmem[m_addr[15:1]] = m_wdata;
        else if (m_addr[0]) mmem[m_addr[15:1]][15:8] = m_wdata[7:0];
        else mmem[m_addr[15:1]][7:0] = m_wdata[7:0];
      end
      if (m_ackon) begin
        if (!(m_win ? dbg_req : cpu_req)) begin m_act = 0; m_ackon = 0; end
      end else if (m_cnt == m_lat) m_ackon = 1;
    end
  end
  bit chk_en = 0;
  always begin
    @(negedge clk_in);
    if (chk_en) begin
      check("busy", busy, m_act);
      check("ram_wren", ram_wren, m_act && m_cnt == 0 && m_we && !m_err);
      check("cpu_ack", cpu_ack, m_ackon && !m_win);
      check("dbg_ack", dbg_ack, m_ackon && m_win);
      if (m_act && m_cnt == 0 && m_we && !m_err) begin
        check("ram_addr", ram_addr, m_addr[15:1]);
        check("ram_data", ram_data, m_bsel ? {m_wdata[7:0], m_wdata[7:0]} : m_wdata);
        check("ram_byteena", ram_byteena, !m_bsel ? 2'b11 : m_addr[0] ? 2'b10 : 2'b01);
      end
      if (m_ackon && !m_win) check("cpu_err", cpu_err, m_err);
      if (m_ackon && !m_win && (!m_we || m_err)) check("cpu_rdata", cpu_rdata, m_rdata);
      if (m_ackon && m_win && !m_we) check("dbg_rdata", dbg_rdata, m_rdata);
    end
  end
  int cpu_ack_cyc = 0, dbg_ack_cyc = 0, wren_cyc = 0;
  logic [15:0] last_cpu_rdata = 0, last_dbg_rdata = 0, last_ram_data = 0;
  logic [1:0] last_be = 0;
  logic last_cpu_err = 0;
  bit pc = 0, pd = 0;
  int grants[$];
  always begin
    @(negedge clk_in);
    if (cpu_ack) begin cpu_ack_cyc++; last_cpu_rdata = cpu_rdata; last_cpu_err = cpu_err; end
    if (dbg_ack) begin dbg_ack_cyc++; last_dbg_rdata = dbg_rdata; end
    if (ram_wren) begin wren_cyc++; last_ram_data = ram_data; last_be = ram_byteena; end
    if (cpu_ack && !pc) grants.push_back(0);
    if (dbg_ack && !pd) grants.push_back(1);
    pc = cpu_ack; pd = dbg_ack;
  end
  // hold < 0: drop req after one cycle, before any ack can arrive
  task automatic cpu_txn(input bit we, input bit bs, input logic [15:0] a, input logic [15:0] d, input int hold);
    int n;
    cpu_we = we; cpu_byte = bs; cpu_addr = a; cpu_wdata = d; cpu_req = 1;
    if (hold < 0) begin
      @(negedge clk_in);
      cpu_req = 0; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); cpu_we = 1'($urandom); cpu_byte = 1'($urandom);
      repeat (6) @(negedge clk_in);
    end else begin
      n = 0;
      do begin @(negedge clk_in); n++; end while (!cpu_ack && n < 60);
      check("cpu_ack_wait", cpu_ack, 1'b1);
      repeat (hold) @(negedge clk_in);
      cpu_req = 0; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); cpu_we = 1'($urandom); cpu_byte = 1'($urandom);
      n = 0;
      while (cpu_ack && n < 60) begin @(negedge clk_in); n++; end
      check("cpu_ack_drop", cpu_ack, 1'b0);
    end
  endtask
  task automatic dbg_txn(input bit we, input logic [15:0] a, input logic [15:0] d, input int hold);
    int n;
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1;
    if (hold < 0) begin
      @(negedge clk_in);
      dbg_req = 0; dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom); dbg_we = 1'($urandom);
      repeat (6) @(negedge clk_in);
    end else begin
      n = 0;
      do begin @(negedge clk_in); n++; end while (!dbg_ack && n < 60);
      check("dbg_ack_wait", dbg_ack, 1'b1);
      repeat (hold) @(negedge clk_in);
      dbg_req = 0; dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom); dbg_we = 1'($urandom);
      n = 0;
      while (dbg_ack && n < 60) begin @(negedge clk_in); n++; end
      check("dbg_ack_drop", dbg_ack, 1'b0);
    end
  endtask
  function automatic int rnd_hold();
    if ($urandom_range(0, 7) == 0) return -1;
    return int'($urandom_range(0, 3));
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  int base, base_w;
  int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  initial begin
    for (int i = 0; i < 32768; i++) begin mem[i] = 0; mmem[i] = 0; end
    for (int i = 0; i < 64; i++) begin mem[i] = 16'($urandom); mmem[i] = mem[i]; end
    mem[8] = 16'hBEEF; mmem[8] = 16'hBEEF;
    mem[16] = 16'h1234; mmem[16] = 16'h1234;
    repeat (3) @(negedge clk_in);
    check("rst_busy", busy, 0);
    check("rst_ack", {cpu_ack, dbg_ack, cpu_err, ram_wren}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_be", ram_byteena, 0);
    reset = 0; chk_en = 1;
    @(negedge clk_in);
    cpu_we = 0; cpu_byte = 0; cpu_addr = 16'h0010; cpu_req = 1;
    @(negedge clk_in);
    check("r44_busy", busy, 1); check("r44_ram_addr", ram_addr, 8); check("r44_ack_t1", cpu_ack, 0);
    @(negedge clk_in); check("r44_ack_t2", cpu_ack, 0);
    @(negedge clk_in); check("r44_ack_t3", cpu_ack, 0);
    @(negedge clk_in); check("r44_ack_rise", cpu_ack, 1); check("r44_rdata", cpu_rdata, 16'hBEEF);
    @(negedge clk_in); check("r44_ack_hold", cpu_ack, 1);
    cpu_req = 0;
    @(negedge clk_in); check("r44_ack_fall", cpu_ack, 0); check("r44_idle", busy, 0);
    @(negedge clk_in);
    base_w = wren_cyc;
    cpu_txn(1, 1, 16'h0011, 16'h00A5, 0);
    check("r45_wren_pulses", wren_cyc - base_w, 1);
    check("r45_ram_data", last_ram_data, 16'hA5A5);
    check("r45_byteena", last_be, 2'b10);
    cpu_txn(0, 1, 16'h0011, 16'h0, 1);
    check("r45_byte_read", last_cpu_rdata, 16'h00A5);
    base_w = wren_cyc;
    cpu_txn(0, 0, 16'h0003, 16'h0, 0);
    check("r46_err", last_cpu_err, 1); check("r46_rdata", last_cpu_rdata, 0);
    cpu_txn(1, 0, 16'h0005, 16'hFFFF, 0);
    check("r46_werr", last_cpu_err, 1);
    check("r46_no_wren", wren_cyc - base_w, 0);
    base = cpu_ack_cyc;
    cpu_txn(1, 0, 16'h0030, 16'h5A5A, -1);
    check("r37_ack_pulse", cpu_ack_cyc - base, 1);
    cpu_txn(0, 0, 16'h0030, 16'h0, 0);
    check("r37_written", last_cpu_rdata, 16'h5A5A);
    grants.delete();
    fork
      repeat (8) cpu_txn(0, 0, 16'h0040, 16'h0, 0);
      repeat (2) dbg_txn(0, 16'h0042, 16'h0, 0);
    join
    check("r47_grants", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++) check("r47_order", grants[i], exp_order[i]);
    @(negedge clk_in);
    base = dbg_ack_cyc;
    dbg_we = 0; dbg_addr = 16'h0021; dbg_req = 1;
    @(negedge clk_in);
    @(negedge clk_in);
    check("r48_busy_capture", busy, 1);
    #1 reset = 1;
    #1;
    check("r48_ctl_zero", {busy, cpu_ack, dbg_ack, cpu_err, ram_wren, ram_byteena}, 0);
    check("r48_ram_zero", {ram_addr, ram_data}, 0);
    check("r48_rdata_zero", {cpu_rdata, dbg_rdata}, 0);
    dbg_req = 0;
    repeat (3) @(negedge clk_in);
    reset = 0;
    repeat (3) @(negedge clk_in);
    check("r48_no_ack", dbg_ack_cyc - base, 0);
    dbg_txn(0, 16'h0021, 16'h0, 0);
    check("r48_fresh_read", last_dbg_rdata, 16'h1234);
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
        cpu_txn(1'($urandom), 1'($urandom), 16'($urandom_range(0, 127)), 16'($urandom), rnd_hold());
      end
      for (int j = 0; j < 20; j++) begin
        repeat ($urandom_range(0, 5)) @(negedge clk_in);
        dbg_txn(1'($urandom), 16'($urandom_range(0, 127)), 16'($urandom), rnd_hold());
      end
    join
    repeat (4) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
